// File: rtl/fifo_ff_sync_v2.sv
// Single-clock flip-flop FIFO with non-power-of-two depth, optional first-word-fall-through
// output, programmable almost-full/empty thresholds, flush and sticky error flags.
module fifo_ff_sync_v2 #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int ADDR     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ADDR:0]    occup,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam logic [ADDR:0]   DEPTH_W  = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0]   AF_W     = (ADDR+1)'(AF_THRESH);
  localparam logic [ADDR:0]   AE_W     = (ADDR+1)'(AE_THRESH);
  localparam logic [ADDR:0]   OCC_ZERO = '0;
  localparam logic [ADDR-1:0] LAST_PTR = ADDR'(DEPTH - 1);
  localparam logic [ADDR-1:0] PTR_ONE  = ADDR'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]    occup_q, occup_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ae_q, ae_d;
  logic             af_q, af_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_acc;
  logic             rd_acc;
  logic             load_head;
  logic [ADDR:0]    occ_after_rd;
  logic [ADDR-1:0]  wr_ptr_inc;
  logic [ADDR-1:0]  rd_ptr_inc;

  always_comb begin
    wr_acc       = wr_en & ~full_q & ~flush;
    rd_acc       = rd_en & ~empty_q & ~flush;
    wr_ptr_inc   = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
    rd_ptr_inc   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
    occ_after_rd = occup_q - (ADDR+1)'(rd_acc);
    load_head    = rd_acc | (wr_acc & empty_q);

    wr_ptr_d    = wr_acc ? wr_ptr_inc : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_inc : rd_ptr_q;
    occup_d     = occ_after_rd + (ADDR+1)'(wr_acc);
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occup_d  = '0;
    end

    if (FWFT != 0) begin
      // Memory keeps every stored word; the output register mirrors the head.
      // When the new head is the word being written this edge, take it from wr_data.
      if (load_head) begin
        if (occ_after_rd == OCC_ZERO) begin
          if (wr_acc) rd_data_d = wr_data;
        end else begin
          rd_data_d = mem_q[rd_ptr_d];
        end
      end
      rd_valid_d = (occup_d != OCC_ZERO);
    end else begin
      if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
      rd_valid_d = rd_acc;
    end

    empty_d = (occup_d == OCC_ZERO);
    full_d  = (occup_d == DEPTH_W);
    ae_d    = (occup_d <= AE_W);
    af_d    = (occup_d >= AF_W);

    // Set wins over clear so an error in the clearing cycle is not lost.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en & full_q & ~flush)  overflow_d  = 1'b1;
    if (rd_en & empty_q & ~flush) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occup_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ae_q        <= 1'b1;
      af_q        <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occup_q     <= occup_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ae_q        <= ae_d;
      af_q        <= af_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign occup        = occup_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ff_sync_v2.sv
// Directed bench: a DEPTH=5 standard-mode FIFO and a DEPTH=4 fall-through FIFO side by side.
module tb_fifo_ff_sync_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // standard-mode instance
  logic       s_rst, s_flush, s_wr_en, s_rd_en, s_err_clr;
  logic [7:0] s_wr_data, s_rd_data;
  logic       s_rd_valid, s_empty, s_full, s_ae, s_af, s_overflow, s_underflow;
  logic [3:0] s_occup;

  // fall-through instance
  logic       f_rst, f_flush, f_wr_en, f_rd_en, f_err_clr;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_rd_valid, f_empty, f_full, f_ae, f_af, f_overflow, f_underflow;
  logic [2:0] f_occup;

  fifo_ff_sync_v2 #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_std (
    .clk(clk), .rst(s_rst), .flush(s_flush), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty),
    .full(s_full), .almost_empty(s_ae), .almost_full(s_af), .occup(s_occup),
    .overflow(s_overflow), .underflow(s_underflow), .err_clr(s_err_clr)
  );

  fifo_ff_sync_v2 #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u_fw (
    .clk(clk), .rst(f_rst), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
    .full(f_full), .almost_empty(f_ae), .almost_full(f_af), .occup(f_occup),
    .overflow(f_overflow), .underflow(f_underflow), .err_clr(f_err_clr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic s_idle;
    s_wr_en = 0; s_rd_en = 0; s_flush = 0; s_err_clr = 0; s_rst = 0;
  endtask

  task automatic test_reset;
    s_rst = 1; f_rst = 1;
    tick; tick;
    n_checks++; if (s_occup !== 4'd0) begin n_fail++; $display("FAIL rst_occup: got %0d exp 0", s_occup); end
    n_checks++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100) begin n_fail++; $display("FAIL rst_flags: got %b exp 1100", {s_empty, s_ae, s_full, s_af}); end
    n_checks++; if ({s_rd_valid, s_overflow, s_underflow} !== 3'b000) begin n_fail++; $display("FAIL rst_valid_err: got %b exp 000", {s_rd_valid, s_overflow, s_underflow}); end
    n_checks++; if (s_rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rd_data: got %h exp 00", s_rd_data); end
    n_checks++; if ({f_empty, f_rd_valid, f_occup} !== {1'b1, 1'b0, 3'd0}) begin n_fail++; $display("FAIL rst_fwft: got e=%b v=%b o=%0d exp e=1 v=0 o=0", f_empty, f_rd_valid, f_occup); end
    s_rst = 0; f_rst = 0;
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 5; i++) begin
      s_wr_en = 1; s_wr_data = 8'(8'hA0 + i);
      tick;
      n_checks++; if (s_occup !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_occup%0d: got %0d exp %0d", i, s_occup, i + 1); end
      n_checks++; if (s_af !== (i >= 2)) begin n_fail++; $display("FAIL fill_af%0d: got %b exp %b", i, s_af, (i >= 2)); end
      n_checks++; if (s_ae !== (i < 1)) begin n_fail++; $display("FAIL fill_ae%0d: got %b exp %b", i, s_ae, (i < 1)); end
    end
    s_wr_en = 0;
    n_checks++; if (s_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b exp 1", s_full); end
    for (int i = 0; i < 5; i++) begin
      s_rd_en = 1;
      tick;
      n_checks++; if (s_rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid%0d: got %b exp 1", i, s_rd_valid); end
      n_checks++; if (s_rd_data !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL drain_data%0d: got %h exp %h", i, s_rd_data, 8'(8'hA0 + i)); end
    end
    s_rd_en = 0;
    n_checks++; if (s_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b exp 1", s_empty); end
    tick;
    n_checks++; if ({s_rd_valid, s_rd_data} !== {1'b0, 8'hA4}) begin n_fail++; $display("FAIL drain_hold: got v=%b d=%h exp v=0 d=a4", s_rd_valid, s_rd_data); end
    n_checks++; if (s_underflow !== 1'b0) begin n_fail++; $display("FAIL drain_no_underflow: got %b exp 0", s_underflow); end
  endtask

  task automatic test_wrap_interleave;
    for (int i = 0; i < 2; i++) begin
      s_wr_en = 1; s_wr_data = 8'(8'hB0 + i);
      tick;
    end
    for (int i = 0; i < 12; i++) begin
      s_wr_en = 1; s_rd_en = 1; s_wr_data = 8'(8'hB2 + i);
      tick;
      n_checks++; if (s_rd_data !== 8'(8'hB0 + i)) begin n_fail++; $display("FAIL wrap_data%0d: got %h exp %h", i, s_rd_data, 8'(8'hB0 + i)); end
      n_checks++; if (s_occup !== 4'd2) begin n_fail++; $display("FAIL wrap_occup%0d: got %0d exp 2", i, s_occup); end
    end
    s_wr_en = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_checks++; if (s_rd_data !== 8'(8'hBC + i)) begin n_fail++; $display("FAIL wrap_tail%0d: got %h exp %h", i, s_rd_data, 8'(8'hBC + i)); end
    end
    s_rd_en = 0;
    n_checks++; if (s_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b exp 1", s_empty); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) begin
      s_wr_en = 1; s_wr_data = 8'(8'hC0 + i);
      tick;
    end
    s_rd_en = 1; s_wr_data = 8'h55;
    tick;
    s_idle();
    n_checks++; if (s_rd_data !== 8'hC0) begin n_fail++; $display("FAIL ovf_head: got %h exp c0", s_rd_data); end
    n_checks++; if ({s_overflow, s_full, s_occup} !== {1'b1, 1'b0, 4'd4}) begin n_fail++; $display("FAIL ovf_state: got ovf=%b full=%b occ=%0d exp 1 0 4", s_overflow, s_full, s_occup); end
    s_err_clr = 1;
    tick;
    s_err_clr = 0;
    n_checks++; if (s_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b exp 0", s_overflow); end
    s_wr_en = 1; s_wr_data = 8'hC5;
    tick;
    s_err_clr = 1; s_wr_data = 8'h66;
    tick;
    s_idle();
    n_checks++; if ({s_overflow, s_occup} !== {1'b1, 4'd5}) begin n_fail++; $display("FAIL ovf_set_wins: got ovf=%b occ=%0d exp 1 5", s_overflow, s_occup); end
    s_err_clr = 1;
    tick;
    s_err_clr = 0;
    // head is now C1 after the overflow cycle popped C0
    for (int i = 0; i < 2; i++) begin
      s_rd_en = 1;
      tick;
      n_checks++; if (s_rd_data !== 8'(8'hC1 + i)) begin n_fail++; $display("FAIL ovf_order%0d: got %h exp %h", i, s_rd_data, 8'(8'hC1 + i)); end
    end
    s_rd_en = 0;
    n_checks++; if (s_occup !== 4'd3) begin n_fail++; $display("FAIL ovf_occ3: got %0d exp 3", s_occup); end
  endtask

  task automatic test_flush;
    s_flush = 1; s_wr_en = 1; s_rd_en = 1; s_wr_data = 8'h77;
    tick;
    s_idle();
    n_checks++; if ({s_occup, s_empty, s_rd_valid} !== {4'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL flush_state: got occ=%0d e=%b v=%b exp 0 1 0", s_occup, s_empty, s_rd_valid); end
    n_checks++; if ({s_overflow, s_underflow} !== 2'b00) begin n_fail++; $display("FAIL flush_err: got %b exp 00", {s_overflow, s_underflow}); end
    n_checks++; if (s_rd_data !== 8'hC2) begin n_fail++; $display("FAIL flush_rd_hold: got %h exp c2", s_rd_data); end
    s_wr_en = 1; s_wr_data = 8'hD0;
    tick;
    s_wr_en = 0; s_rd_en = 1;
    tick;
    s_rd_en = 0;
    n_checks++; if ({s_rd_data, s_rd_valid} !== {8'hD0, 1'b1}) begin n_fail++; $display("FAIL flush_post: got d=%h v=%b exp d0 1", s_rd_data, s_rd_valid); end
    n_checks++; if (s_empty !== 1'b1) begin n_fail++; $display("FAIL flush_post_empty: got %b exp 1", s_empty); end
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 6; i++) begin
      s_wr_en = 1; s_wr_data = 8'(8'hE0 + i);
      tick;
    end
    s_wr_en = 0; s_rd_en = 1;
    tick;
    s_rd_en = 0;
    n_checks++; if ({s_occup, s_overflow, s_rd_data} !== {4'd4, 1'b1, 8'hE0}) begin n_fail++; $display("FAIL mid_pre: got occ=%0d ovf=%b d=%h exp 4 1 e0", s_occup, s_overflow, s_rd_data); end
    s_rst = 1; s_wr_en = 1; s_rd_en = 1; s_wr_data = 8'h99;
    tick;
    s_idle();
    n_checks++; if ({s_occup, s_empty, s_ae, s_full, s_af} !== {4'd0, 4'b1100}) begin n_fail++; $display("FAIL mid_rst_flags: got occ=%0d flags=%b exp 0 1100", s_occup, {s_empty, s_ae, s_full, s_af}); end
    n_checks++; if ({s_rd_data, s_rd_valid, s_overflow, s_underflow} !== {8'h00, 3'b000}) begin n_fail++; $display("FAIL mid_rst_out: got d=%h v=%b ovf=%b udf=%b exp 00 0 0 0", s_rd_data, s_rd_valid, s_overflow, s_underflow); end
    s_wr_en = 1; s_wr_data = 8'hF0;
    tick;
    s_wr_en = 0; s_rd_en = 1;
    tick;
    s_rd_en = 0;
    n_checks++; if ({s_rd_data, s_empty} !== {8'hF0, 1'b1}) begin n_fail++; $display("FAIL mid_post: got d=%h e=%b exp f0 1", s_rd_data, s_empty); end
  endtask

  task automatic test_fwft;
    f_wr_en = 1; f_wr_data = 8'h11;
    tick;
    n_checks++; if ({f_rd_valid, f_rd_data, f_occup} !== {1'b1, 8'h11, 3'd1}) begin n_fail++; $display("FAIL fw_bypass: got v=%b d=%h o=%0d exp 1 11 1", f_rd_valid, f_rd_data, f_occup); end
    f_rd_en = 1; f_wr_data = 8'h22;
    tick;
    n_checks++; if ({f_rd_valid, f_rd_data, f_occup} !== {1'b1, 8'h22, 3'd1}) begin n_fail++; $display("FAIL fw_chain22: got v=%b d=%h o=%0d exp 1 22 1", f_rd_valid, f_rd_data, f_occup); end
    f_wr_data = 8'h33;
    tick;
    n_checks++; if ({f_rd_valid, f_rd_data} !== {1'b1, 8'h33}) begin n_fail++; $display("FAIL fw_chain33: got v=%b d=%h exp 1 33", f_rd_valid, f_rd_data); end
    f_wr_en = 0;
    tick;
    n_checks++; if ({f_rd_valid, f_empty, f_underflow} !== 3'b010) begin n_fail++; $display("FAIL fw_popped: got v=%b e=%b u=%b exp 0 1 0", f_rd_valid, f_empty, f_underflow); end
    tick;
    f_rd_en = 0;
    n_checks++; if (f_underflow !== 1'b1) begin n_fail++; $display("FAIL fw_underflow: got %b exp 1", f_underflow); end
    for (int i = 0; i < 3; i++) begin
      f_wr_en = 1; f_wr_data = 8'(8'h44 + 8'h11 * i);
      tick;
    end
    f_wr_en = 0;
    n_checks++; if ({f_rd_data, f_occup, f_af} !== {8'h44, 3'd3, 1'b1}) begin n_fail++; $display("FAIL fw_fill: got d=%h o=%0d af=%b exp 44 3 1", f_rd_data, f_occup, f_af); end
    f_rd_en = 1;
    tick;
    n_checks++; if (f_rd_data !== 8'h55) begin n_fail++; $display("FAIL fw_pop55: got %h exp 55", f_rd_data); end
    tick;
    n_checks++; if ({f_rd_data, f_occup} !== {8'h66, 3'd1}) begin n_fail++; $display("FAIL fw_pop66: got d=%h o=%0d exp 66 1", f_rd_data, f_occup); end
    f_wr_en = 1; f_wr_data = 8'h77;
    tick;
    f_wr_en = 0;
    n_checks++; if ({f_rd_valid, f_rd_data, f_occup} !== {1'b1, 8'h77, 3'd1}) begin n_fail++; $display("FAIL fw_last_bypass: got v=%b d=%h o=%0d exp 1 77 1", f_rd_valid, f_rd_data, f_occup); end
    tick;
    f_rd_en = 0;
    n_checks++; if ({f_rd_valid, f_empty} !== 2'b01) begin n_fail++; $display("FAIL fw_final_empty: got v=%b e=%b exp 0 1", f_rd_valid, f_empty); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst = 1; s_flush = 0; s_wr_en = 0; s_rd_en = 0; s_err_clr = 0; s_wr_data = '0;
    f_rst = 1; f_flush = 0; f_wr_en = 0; f_rd_en = 0; f_err_clr = 0; f_wr_data = '0;
    #2;
    test_reset();
    test_fill_drain();
    test_wrap_interleave();
    test_overflow();
    test_flush();
    test_reset_midstream();
    test_fwft();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
